// File: rtl/stream_popcount.sv
// stream_popcount: counts the ones across every beat of a framed input stream
// and emits one total per frame.
//
// Pipeline:
//   stage 1 : registered popcount of the accepted beat, plus its last flag
//   stage 2 : accumulator acc_q and frame FSM; a last beat writes the output
//             register, so valid_o rises two cycles after the last beat is
//             accepted
//
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   clear_i       synchronous flush of the pipeline, accumulator and result
//   data_i, last_i, valid_i / ready_o   input beat stream
//   count_o, overflow_o, valid_o / ready_i   per-frame result stream
//
// Build option: define STREAM_POPCOUNT_SATURATE_EN to make an overflowing
// frame saturate at 2^ACC_WIDTH-1. Without it the total wraps modulo
// 2^ACC_WIDTH. In both builds overflow_o is set for that frame.
module stream_popcount #(
  parameter int DATA_WIDTH = 64,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [ACC_WIDTH-1:0]  count_o,
  output logic                  overflow_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("stream_popcount: DATA_WIDTH must be >= 1");
  end
  if (ACC_WIDTH < CNT_W) begin : g_bad_acc_width
    $error("stream_popcount: ACC_WIDTH must be >= $clog2(DATA_WIDTH)+1");
  end

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             last;
  } s1_t;

  typedef enum logic {IDLE, ACCUM} state_t;

  // stage 1
  s1_t                  s1_q;
  logic                 s1_vld_q;
  logic [CNT_W-1:0]     pop;

  // stage 2 / output register
  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_new;
  logic                 ovf_q, ovf_new;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] base;
  logic                 out_vld_q, out_ovf_q;
  logic [ACC_WIDTH-1:0] out_cnt_q;

  logic                 out_free, s2_take, accept;

  always_comb begin
    pop = '0;
    for (int i = 0; i < DATA_WIDTH; i++) pop = pop + CNT_W'(data_i[i]);
  end

  // The output register can take a new result if it is empty or is being
  // consumed this cycle, which lets back-to-back results go without a bubble.
  assign out_free = !out_vld_q || ready_i;
  // Non-last beats never wait on the output; only a closing beat can stall.
  assign s2_take  = s1_vld_q && (!s1_q.last || out_free);
  // Gated by rst_i so the stream is closed while reset is held.
  assign ready_o  = !rst_i && !clear_i && (!s1_vld_q || s2_take);
  assign accept   = valid_i && ready_o;

  // The first beat of a frame loads its own count, so a stale acc_q or a
  // sticky overflow from the previous frame can never leak into this one.
  always_comb begin
    base    = (state_q == ACCUM) ? acc_q : '0;
    sum     = {1'b0, base} + (ACC_WIDTH+1)'(s1_q.cnt);
    ovf_new = ((state_q == ACCUM) && ovf_q) || sum[ACC_WIDTH];
`ifdef STREAM_POPCOUNT_SATURATE_EN
    acc_new = ovf_new ? '1 : sum[ACC_WIDTH-1:0];
`else
    acc_new = sum[ACC_WIDTH-1:0];
`endif
    state_d = state_q;
    if (s2_take) state_d = s1_q.last ? IDLE : ACCUM;
    if (clear_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
    end else if (clear_i) begin
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
    end else if (accept) begin
      s1_q     <= '{cnt: pop, last: last_i};
      s1_vld_q <= 1'b1;
    end else if (s2_take) begin
      s1_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear_i || (s2_take && s1_q.last)) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (s2_take) begin
      acc_q <= acc_new;
      ovf_q <= ovf_new;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_vld_q <= 1'b0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
    end else if (clear_i) begin
      out_vld_q <= 1'b0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
    end else if (s2_take && s1_q.last) begin
      out_vld_q <= 1'b1;
      out_cnt_q <= acc_new;
      out_ovf_q <= ovf_new;
    end else if (ready_i) begin
      out_vld_q <= 1'b0;
    end
  end

  assign valid_o    = out_vld_q;
  assign count_o    = out_cnt_q;
  assign overflow_o = out_ovf_q;

endmodule

// File: doc/stream_popcount.md
STREAM_POPCOUNT -- requirements
Module: stream_popcount

Interface
REQ-001 Parameter DATA_WIDTH, default 64, beat width in bits; SHALL be >= 1.
REQ-002 Parameter ACC_WIDTH, default 16, accumulator/result width; SHALL be >= $clog2(DATA_WIDTH)+1 (elaboration error otherwise).
REQ-003 Port clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_i  input  1  reset; asynchronous and active-high.
REQ-005 Port clear_i  input  1  synchronous flush of all state.
REQ-006 Port data_i  input  DATA_WIDTH  input beat.
REQ-007 Port last_i  input  1  beat closes the current frame.
REQ-008 Port valid_i  input  1  input beat valid.
REQ-009 Port ready_o  output  1  input beat accepted when valid_i && ready_o.
REQ-010 Port count_o  output  ACC_WIDTH  total ones in the completed frame.
REQ-011 Port overflow_o  output  1  frame total exceeded 2^ACC_WIDTH-1; qualified by valid_o.
REQ-012 Port valid_o  output  1  result valid.
REQ-013 Port ready_i  input  1  result consumed when valid_o && ready_i.

Function
REQ-014 Stage 1 SHALL register popcount(data_i) (width $clog2(DATA_WIDTH)+1) plus last_i and a stage-valid bit on every accepted beat.
REQ-015 Stage 2 SHALL add the stage-1 count to acc_q zero-extended to ACC_WIDTH; the first beat of a frame SHALL load acc_q with its own count.
REQ-016 Frame state machine: IDLE (no partial frame) -> ACCUM on a non-last beat; ACCUM -> IDLE when a last beat reaches stage 2; IDLE -> IDLE on a single-beat frame.
REQ-017 When a last beat reaches stage 2 the final sum and overflow flag SHALL be written to the output register and valid_o SHALL assert the next cycle; acc_q SHALL be cleared.
REQ-018 Latency: last beat accepted in cycle N -> valid_o high in cycle N+2.
REQ-019 valid_o, count_o and overflow_o SHALL remain stable until valid_o && ready_i.
REQ-020 A stage-1 last beat SHALL stall in stage 1 while the output register holds an unconsumed result; non-last beats SHALL continue to accumulate.
REQ-021 ready_o SHALL be high when stage 1 is empty or its content moves to stage 2 in the same cycle; full throughput is one beat per cycle with ready_i high.
REQ-022 A result consumed in the same cycle that a new last beat reaches stage 2 SHALL be replaced without a bubble.
REQ-023 Overflow SHALL be sticky within a frame and cleared at frame start.
REQ-024 clear_i SHALL take precedence over all handshakes, empty both stages, clear acc_q, deassert valid_o and discard any partial frame; ready_o SHALL be low during the clear_i cycle.
REQ-025 valid_i with last_i and data_i = 0 SHALL produce count_o = 0.

Reset
REQ-026 While rst_i is high: valid_o = 0, count_o = 0, overflow_o = 0, ready_o = 0, acc_q = 0, FSM = IDLE, both stages empty.
REQ-027 ready_o SHALL go high in the first cycle after rst_i deasserts; a frame in flight at reset SHALL be lost with no result emitted.

Configuration
REQ-028 Macro STREAM_POPCOUNT_SATURATE_EN defined: acc_q and count_o SHALL saturate at 2^ACC_WIDTH-1 on overflow, overflow_o = 1.
REQ-029 Macro undefined: acc_q SHALL wrap modulo 2^ACC_WIDTH, overflow_o = 1 with the wrapped count.

Verification
REQ-030 DATA_WIDTH=64: beats 0xFFFF_FFFF_FFFF_FFFF, 0x1, 0xF0 (last) back-to-back, ready_i=1 -> count_o=69, overflow_o=0, valid_o exactly 2 cycles after the last beat.
REQ-031 Single-beat frames 0x3, 0x7, 0x0 every cycle, ready_i=1 -> results 2, 3, 0 on consecutive cycles, ready_o never low.
REQ-032 ready_i=0 for 5 cycles with result pending, next frame 3 beats then last -> first result held stable, ready_o low only while last beat waits, second result correct after release.
REQ-033 ACC_WIDTH=7, DATA_WIDTH=64, three all-ones beats (192) -> with macro count_o=127, overflow_o=1; without macro count_o=64, overflow_o=1.
REQ-034 clear_i pulsed mid-frame after 2 beats, then frame 0x1 (last) -> count_o=1; no result for the discarded frame.
REQ-035 rst_i asserted mid-frame asynchronously between clock edges -> valid_o, ready_o low immediately; after release, frame 0xFF (last) -> count_o=8.
